// File: rtl/instr_decoder.sv
// instr_decoder -- RV32I instruction field decoder for the decode stage.
//
// Splits a 32-bit instruction into register indices, a 4-bit ALU function
// code and a sign-extended 32-bit immediate. The decode path is purely
// combinational by default. A clocked sticky flag records any illegal
// opcode seen since the last reset, for debug.
//
// Build option:
//   INSTR_DECODER_OUTREG_EN  when defined, alu_funct/rs1/rs2/rd/immed/illegal
//                            are registered on clk (one-cycle latency), and
//                            illegal_seen samples the registered illegal.
//
// Ports:
//   clk              clock
//   rst              synchronous active-high reset (forces NOP decode)
//   instr[31:0]      instruction word
//   controlOverride  1 = force alu_funct to ADD
//   alu_funct[3:0]   ALU function code {b3, funct3}
//   rs1/rs2/rd[4:0]  raw register index fields
//   immed[31:0]      sign-extended immediate for the opcode's format
//   illegal          opcode is not a supported RV32I major opcode
//   illegal_seen     sticky OR of illegal, cleared by reset
module instr_decoder #(
  parameter int N               = 32,
  parameter int INSTR_REG_WIDTH = 5,
  parameter int ALU_FUNCT_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               instr,
  input  logic                       controlOverride,
  output logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
  output logic [INSTR_REG_WIDTH-1:0] rs1,
  output logic [INSTR_REG_WIDTH-1:0] rs2,
  output logic [INSTR_REG_WIDTH-1:0] rd,
  output logic [N-1:0]               immed,
  output logic                       illegal,
  output logic                       illegal_seen
);

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0]                 opcode;
  logic [2:0]                 funct3;
  logic [ALU_FUNCT_WIDTH-1:0] alu_d;
  logic [INSTR_REG_WIDTH-1:0] rs1_d, rs2_d, rd_d;
  logic [N-1:0]               imm_d;
  logic                       ill_d;
  logic                       legal_op;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  always_comb begin
    alu_d = '0;
    if (!rst && !controlOverride) begin
      case (opcode)
        OP_OP:   alu_d = {instr[30], funct3};
        // Only SRLI/SRAI use bit 30 as a function bit; for the other
        // OP-IMM forms it is immediate data.
        OP_IMM:  alu_d = {(funct3 == 3'b101) & instr[30], funct3};
        default: alu_d = '0;
      endcase
    end
  end

  always_comb begin
    imm_d = '0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR:
        imm_d = {{(N-12){instr[31]}}, instr[31:20]};
      OP_STORE:
        imm_d = {{(N-12){instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm_d = {{(N-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                 instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_d = {instr[31:12], 12'b0};
      OP_JAL:
        imm_d = {{(N-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                 instr[30:21], 1'b0};
      default:
        imm_d = '0;
    endcase
    if (rst) imm_d = '0;
  end

  always_comb begin
    legal_op = 1'b0;
    case (opcode)
      OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC,
      OP_JAL, OP_JALR, OP_FENCE, OP_SYSTEM: legal_op = 1'b1;
      default:                              legal_op = 1'b0;
    endcase
  end

  // Every legal major opcode ends in 2'b11; the explicit check keeps the
  // compressed-encoding space flagged even if the opcode list changes.
  assign ill_d = !rst && (!legal_op || (instr[1:0] != 2'b11));

  assign rs1_d = rst ? '0 : instr[19:15];
  assign rs2_d = rst ? '0 : instr[24:20];
  assign rd_d  = rst ? '0 : instr[11:7];

`ifdef INSTR_DECODER_OUTREG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_funct <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      immed     <= '0;
      illegal   <= 1'b0;
    end else begin
      alu_funct <= alu_d;
      rs1       <= rs1_d;
      rs2       <= rs2_d;
      rd        <= rd_d;
      immed     <= imm_d;
      illegal   <= ill_d;
    end
  end
`else
  assign alu_funct = alu_d;
  assign rs1       = rs1_d;
  assign rs2       = rs2_d;
  assign rd        = rd_d;
  assign immed     = imm_d;
  assign illegal   = ill_d;
`endif

  // Samples the output-side illegal so the sticky flag lines up with what
  // downstream logic observed.
  always_ff @(posedge clk) begin
    if (rst)          illegal_seen <= 1'b0;
    else if (illegal) illegal_seen <= 1'b1;
  end

endmodule

// File: tb/tb_instr_decoder.sv
// Directed, table-driven bench for instr_decoder. Handles both the default
// combinational build and the registered-output build.
module tb_instr_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        controlOverride;
  logic [3:0]  alu_funct;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] immed;
  logic        illegal;
  logic        illegal_seen;

  int checks = 0;
  int errors = 0;

  instr_decoder dut (
    .clk             (clk),
    .rst             (rst),
    .instr           (instr),
    .controlOverride (controlOverride),
    .alu_funct       (alu_funct),
    .rs1             (rs1),
    .rs2             (rs2),
    .rd              (rd),
    .immed           (immed),
    .illegal         (illegal),
    .illegal_seen    (illegal_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        ovr;
    logic [3:0]  alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] i, logic o, logic [3:0] a,
                              logic [4:0] r1, logic [4:0] r2, logic [4:0] d,
                              logic [31:0] im, logic il);
    vec_t v;
    v.instr = i; v.ovr = o; v.alu = a; v.rs1 = r1; v.rs2 = r2;
    v.rd = d; v.imm = im; v.ill = il;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Wait until the outputs reflect the inputs just driven.
  task automatic settle();
`ifdef INSTR_DECODER_OUTREG_EN
    @(posedge clk);
`endif
    #1;
  endtask

  task automatic drive(logic r, logic [31:0] i, logic o);
    @(negedge clk);
    rst = r; instr = i; controlOverride = o;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, ".alu"}, 32'(alu_funct), 32'h0);
    chk({tag, ".rs1"}, 32'(rs1), 32'h0);
    chk({tag, ".rs2"}, 32'(rs2), 32'h0);
    chk({tag, ".rd"},  32'(rd), 32'h0);
    chk({tag, ".imm"}, immed, 32'h0);
    chk({tag, ".ill"}, 32'(illegal), 32'h0);
  endtask

  initial begin
    rst = 1'b1; instr = 32'h0; controlOverride = 1'b0;

    //          instr          ovr alu      rs1 rs2 rd  immed         ill
    vecs.push_back(mk(32'h40208033, 0, 4'b1000, 1,  2,  0,  32'h00000000, 0)); // sub
    vecs.push_back(mk(32'h40208033, 1, 4'b0000, 1,  2,  0,  32'h00000000, 0)); // sub, override
    vecs.push_back(mk(32'hFFF00093, 0, 4'b0000, 0,  31, 1,  32'hFFFFFFFF, 0)); // addi -1
    vecs.push_back(mk(32'h4030D093, 0, 4'b1101, 1,  3,  1,  32'h00000403, 0)); // srai
    vecs.push_back(mk(32'h40002013, 0, 4'b0010, 0,  0,  0,  32'h00000400, 0)); // slti, bit30 = imm
    vecs.push_back(mk(32'h4020D033, 0, 4'b1101, 1,  2,  0,  32'h00000000, 0)); // sra
    vecs.push_back(mk(32'h0020B033, 0, 4'b0011, 1,  2,  0,  32'h00000000, 0)); // sltu
    vecs.push_back(mk(32'hFE112E23, 0, 4'b0000, 2,  1,  28, 32'hFFFFFFFC, 0)); // sw -4
    vecs.push_back(mk(32'hFFC0A083, 0, 4'b0000, 1,  28, 1,  32'hFFFFFFFC, 0)); // lw -4
    vecs.push_back(mk(32'hFE000EE3, 0, 4'b0000, 0,  0,  29, 32'hFFFFFFFC, 0)); // beq -4
    vecs.push_back(mk(32'h123450B7, 0, 4'b0000, 8,  3,  1,  32'h12345000, 0)); // lui
    vecs.push_back(mk(32'h00001017, 0, 4'b0000, 0,  0,  0,  32'h00001000, 0)); // auipc
    vecs.push_back(mk(32'h0000006F, 0, 4'b0000, 0,  0,  0,  32'h00000000, 0)); // jal 0
    vecs.push_back(mk(32'hFF9FF06F, 0, 4'b0000, 31, 25, 0,  32'hFFFFFFF8, 0)); // jal -8
    vecs.push_back(mk(32'h0000000F, 0, 4'b0000, 0,  0,  0,  32'h00000000, 0)); // fence
    vecs.push_back(mk(32'h00000073, 0, 4'b0000, 0,  0,  0,  32'h00000000, 0)); // ecall
    vecs.push_back(mk(32'h0000007F, 0, 4'b0000, 0,  0,  0,  32'h00000000, 1)); // bad opcode
    vecs.push_back(mk(32'h00000012, 0, 4'b0000, 0,  0,  0,  32'h00000000, 1)); // [1:0]!=11

    // Reset state: NOP decode even with a live instruction on the bus.
    drive(1'b1, 32'h40208033, 1'b0);
    settle();
    chk_all_zero("rst");
    @(posedge clk); #1;
    chk("rst.seen", 32'(illegal_seen), 32'h0);

    foreach (vecs[k]) begin
      drive(1'b0, vecs[k].instr, vecs[k].ovr);
      settle();
      chk($sformatf("v%0d.alu", k), 32'(alu_funct), 32'(vecs[k].alu));
      chk($sformatf("v%0d.rs1", k), 32'(rs1), 32'(vecs[k].rs1));
      chk($sformatf("v%0d.rs2", k), 32'(rs2), 32'(vecs[k].rs2));
      chk($sformatf("v%0d.rd", k),  32'(rd), 32'(vecs[k].rd));
      chk($sformatf("v%0d.imm", k), immed, vecs[k].imm);
      chk($sformatf("v%0d.ill", k), 32'(illegal), 32'(vecs[k].ill));
    end

    // Clear the sticky flag left by the illegal table entries.
    drive(1'b1, 32'h00000013, 1'b0);
    settle();
    @(posedge clk); #1;
    chk("clr.seen", 32'(illegal_seen), 32'h0);

    // Legal stream keeps the flag low.
    drive(1'b0, 32'h00000013, 1'b0);
    settle();
    repeat (2) @(posedge clk);
    #1;
    chk("legal.seen", 32'(illegal_seen), 32'h0);

    // All-zero word: illegal now, sticky flag after the next edge.
    drive(1'b0, 32'h00000000, 1'b0);
    settle();
    chk("zero.ill", 32'(illegal), 32'h1);
    chk("zero.seen_pre", 32'(illegal_seen), 32'h0);
    @(posedge clk); #1;
    chk("zero.seen", 32'(illegal_seen), 32'h1);

    // Back to legal: flag holds.
    drive(1'b0, 32'h00000013, 1'b0);
    settle();
    chk("hold.ill", 32'(illegal), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold.seen", 32'(illegal_seen), 32'h1);

    // Reset with an illegal word present: everything reads zero.
    drive(1'b1, 32'h00000000, 1'b1);
    settle();
    chk_all_zero("rst2");
    @(posedge clk); #1;
    chk("rst2.seen", 32'(illegal_seen), 32'h0);
    chk("rst2.ill", 32'(illegal), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
